// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle control FSM (master) and the shared datapath (slave).
interface multicycle_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [5:0]       opcode;
   logic             zero;
   logic             mem_ready;
   logic             pc_en;
   logic             iord;
   logic             mem_write;
   logic             ir_write;
   logic             reg_write;
   logic             reg_dst;
   logic             mem_to_reg;
   logic             alu_src_a;
   logic [1:0]       alu_src_b;
   logic [1:0]       alu_op;
   logic [1:0]       pc_src;
   logic             illegal_op;
   logic [CNT_W-1:0] instr_count;

   modport master (
      input  opcode, zero, mem_ready,
      output pc_en, iord, mem_write, ir_write, reg_write, reg_dst, mem_to_reg,
             alu_src_a, alu_src_b, alu_op, pc_src, illegal_op, instr_count
   );

   modport slave (
      output opcode, zero, mem_ready,
      input  pc_en, iord, mem_write, ir_write, reg_write, reg_dst, mem_to_reg,
             alu_src_a, alu_src_b, alu_op, pc_src, illegal_op, instr_count
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS-subset core plus retired-instruction counter.
// Optional feature: define CTRL_BNE_EN to add bne (opcode 000101) support.
module multicycle_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   multicycle_ctrl_if.master bus
);
   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;
`ifdef CTRL_BNE_EN
   localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

   state_t           state_r, state_nxt_s;
   logic [CNT_W-1:0] cnt_r;
   logic             retire_s, taken_s;
   logic             pc_en_s, iord_s, mem_write_s, ir_write_s, reg_write_s;
   logic             reg_dst_s, mem_to_reg_s, alu_src_a_s, illegal_op_s;
   logic [1:0]       alu_src_b_s, alu_op_s, pc_src_s;

`ifdef CTRL_BNE_EN
   logic             is_bne_r;

   // remember at DECODE whether the branch in flight is bne
   always_ff @(posedge clk) begin
      if (rst) begin
         is_bne_r <= 1'b0;
      end else if (state_r == S_DECODE) begin
         is_bne_r <= (bus.opcode == OP_BNE);
      end else begin
         is_bne_r <= is_bne_r;
      end
   end

   assign taken_s = is_bne_r ? ~bus.zero : bus.zero;
`else
   assign taken_s = bus.zero;
`endif

   // state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= S_FETCH;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // retired-instruction counter, wraps silently
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= '0;
      end else if (retire_s) begin
         cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_r <= cnt_r;
      end
   end

   // next-state and control decode; reset forces every output low
   always_comb begin
      state_nxt_s  = S_FETCH;
      retire_s     = 1'b0;
      pc_en_s      = 1'b0;
      iord_s       = 1'b0;
      mem_write_s  = 1'b0;
      ir_write_s   = 1'b0;
      reg_write_s  = 1'b0;
      reg_dst_s    = 1'b0;
      mem_to_reg_s = 1'b0;
      alu_src_a_s  = 1'b0;
      alu_src_b_s  = 2'b00;
      alu_op_s     = 2'b00;
      pc_src_s     = 2'b00;
      illegal_op_s = 1'b0;
      if (rst) begin
         state_nxt_s = S_FETCH;
      end else begin
         case (state_r)
            S_FETCH: begin
               alu_src_b_s = 2'b01;
               ir_write_s  = bus.mem_ready;
               pc_en_s     = bus.mem_ready;
               state_nxt_s = bus.mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
               alu_src_b_s = 2'b11;
               case (bus.opcode)
                  OP_RTYPE:      state_nxt_s = S_EXEC;
                  OP_LW, OP_SW:  state_nxt_s = S_MEMADR;
                  OP_BEQ:        state_nxt_s = S_BRANCH;
`ifdef CTRL_BNE_EN
                  OP_BNE:        state_nxt_s = S_BRANCH;
`endif
                  OP_ADDI:       state_nxt_s = S_ADDIEX;
                  OP_J:          state_nxt_s = S_JUMP;
                  default: begin
                     state_nxt_s  = S_FETCH;
                     illegal_op_s = 1'b1;
                  end
               endcase
            end
            S_MEMADR: begin
               alu_src_a_s = 1'b1;
               alu_src_b_s = 2'b10;
               state_nxt_s = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
               iord_s      = 1'b1;
               state_nxt_s = bus.mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
               mem_to_reg_s = 1'b1;
               reg_write_s  = 1'b1;
               retire_s     = 1'b1;
            end
            S_MEMWR: begin
               iord_s      = 1'b1;
               mem_write_s = bus.mem_ready;
               retire_s    = bus.mem_ready;
               state_nxt_s = bus.mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
               alu_src_a_s = 1'b1;
               alu_op_s    = 2'b10;
               state_nxt_s = S_ALUWB;
            end
            S_ALUWB: begin
               reg_dst_s   = 1'b1;
               reg_write_s = 1'b1;
               retire_s    = 1'b1;
            end
            S_BRANCH: begin
               alu_src_a_s = 1'b1;
               alu_op_s    = 2'b01;
               pc_src_s    = 2'b01;
               pc_en_s     = taken_s;
               retire_s    = 1'b1;
            end
            S_ADDIEX: begin
               alu_src_a_s = 1'b1;
               alu_src_b_s = 2'b10;
               state_nxt_s = S_ADDIWB;
            end
            S_ADDIWB: begin
               reg_write_s = 1'b1;
               retire_s    = 1'b1;
            end
            S_JUMP: begin
               pc_src_s = 2'b10;
               pc_en_s  = 1'b1;
               retire_s = 1'b1;
            end
            default: state_nxt_s = S_FETCH;
         endcase
      end
   end

   assign bus.pc_en       = pc_en_s;
   assign bus.iord        = iord_s;
   assign bus.mem_write   = mem_write_s;
   assign bus.ir_write    = ir_write_s;
   assign bus.reg_write   = reg_write_s;
   assign bus.reg_dst     = reg_dst_s;
   assign bus.mem_to_reg  = mem_to_reg_s;
   assign bus.alu_src_a   = alu_src_a_s;
   assign bus.alu_src_b   = alu_src_b_s;
   assign bus.alu_op      = alu_op_s;
   assign bus.pc_src      = pc_src_s;
   assign bus.illegal_op  = illegal_op_s;
   assign bus.instr_count = cnt_r;
endmodule
